onehot_index_encoder: RTL



---
 rtl/onehot_index_encoder_pkg.sv | 24 ++
 rtl/onehot_index_encoder_lsb_priority_encoder.sv | 26 ++
 rtl/onehot_index_encoder.sv | 90 +++++++++
 3 files changed

// File: rtl/onehot_index_encoder_pkg.sv
// Shared definitions for the select/arbiter family: FSM encodings and small
// constant helpers for index widths and single-bit masks.
package onehot_index_encoder_pkg;

  localparam int MAX_VEC_W = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int f_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // True when exactly one bit of v is set; narrower vectors are zero-extended.
  function automatic logic f_one_bit_set(input logic [MAX_VEC_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_index_encoder_lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: binary position of the lowest set bit,
// plus any-set and exactly-one-set flags.
module lsb_priority_encoder
  import onehot_index_encoder_pkg::*;
#(
  parameter int inputLen  = 3,
  parameter int outputLen = 1 << inputLen
) (
  input  logic [outputLen-1:0] vec,
  output logic [inputLen-1:0]  idx,
  output logic                 any,
  output logic                 onehot
);

  always_comb begin
    idx = '0;
    // Scan downward so the last hit, the lowest set bit, wins.
    for (int i = outputLen - 1; i >= 0; i--) begin
      if (vec[i]) idx = inputLen'(i);
    end
  end

  assign any    = |vec;
  assign onehot = f_one_bit_set(MAX_VEC_W'(vec));

endmodule

// File: rtl/onehot_index_encoder.sv
// Latches a request mask and walks its set bits, lowest first, emitting one
// binary index per handshake on a valid/ready stream.
module onehot_index_encoder
  import onehot_index_encoder_pkg::*;
#(
  parameter int inputLen  = 3,
  parameter int outputLen = 1 << inputLen
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [outputLen-1:0] req_vec,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic [inputLen-1:0]  idx,
  output logic                 idx_last,
  output logic                 zero_drop,
  output logic                 busy
);

  state_e                 state;
  state_e                 w_state_nxt;
  logic [outputLen-1:0]   pending;
  logic [outputLen-1:0]   w_pending_nxt;
  logic                   r_zero_drop;
  logic                   w_any;
  logic                   w_onehot;
  logic                   w_req_hs;
  logic                   w_idx_hs;

  lsb_priority_encoder #(
    .inputLen  (inputLen),
    .outputLen (outputLen)
  ) u_lsb_enc (
    .vec    (pending),
    .idx    (idx),
    .any    (w_any),
    .onehot (w_onehot)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state == ST_DRAIN);
  assign idx_valid = busy;
  assign idx_last  = busy & w_onehot;
  assign zero_drop = r_zero_drop;

  assign w_req_hs = req_valid & req_ready;
  assign w_idx_hs = idx_valid & idx_ready & w_any;

  always_comb begin
    w_state_nxt   = state;
    w_pending_nxt = pending;
    case (state)
      ST_IDLE: begin
        if (w_req_hs && (req_vec != '0)) begin
          w_pending_nxt = req_vec;
          w_state_nxt   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_idx_hs) begin
          w_pending_nxt = pending & ~(outputLen'(1) << idx);
          if (idx_last) begin
            w_pending_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      default: begin
        w_pending_nxt = '0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pending     <= '0;
      r_zero_drop <= 1'b0;
    end else begin
      state       <= w_state_nxt;
      pending     <= w_pending_nxt;
      // All-zero masks are swallowed in IDLE and only flagged downstream.
      r_zero_drop <= w_req_hs && (req_vec == '0);
    end
  end

endmodule
